// File: rtl/regfile_dump_reader.sv
// Walks every register address, captures each 32-bit word and streams it
// out as a header byte followed by little-endian data bytes.
module regfile_dump_reader #(
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_READ,
    S_SEND,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [31:0]       r_shift;
  logic [1:0]        r_idx;
  logic              w_fire;
  logic              w_last;
  logic              w_word_end;

  assign w_fire     = byte_valid & byte_ready;
  assign w_last     = (r_addr == LAST);
  assign w_word_end = w_fire & (r_idx == 2'd3);
  assign rd_addr    = r_rd_addr;

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_FIN);
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_HDR;
      end
      S_HDR: begin
        byte_valid = 1'b1;
        byte_out   = HEADER;
        if (w_fire) w_next = S_READ;
      end
      S_READ: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        byte_valid = 1'b1;
        byte_out   = r_shift[7:0];
        if (w_word_end) w_next = w_last ? S_FIN : S_READ;
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_rd_addr <= '0;
      r_shift   <= '0;
      r_idx     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) r_addr <= '0;
        end
        S_HDR: begin
          if (w_fire) r_rd_addr <= r_addr;
        end
        S_READ: begin
          r_shift <= rd_data;
          r_idx   <= '0;
        end
        S_SEND: begin
          if (w_fire) begin
            r_shift <= r_shift >> 8;
            r_idx   <= r_idx + 2'd1;
          end
          // rd_addr only moves when the next READ is entered
          if (w_word_end && !w_last) begin
            r_addr    <= r_addr + 1'b1;
            r_rd_addr <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: default build plus a
// 4-register build sharing clock and clear.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        clear;
  logic        start, ready;
  logic        busy, done, bvalid;
  logic [4:0]  addr;
  logic [31:0] rdata;
  logic [7:0]  bout;

  logic        start4, ready4;
  logic        busy4, done4, bvalid4;
  logic [1:0]  addr4;
  logic [31:0] rdata4;
  logic [7:0]  bout4;

  logic [31:0] regs  [0:31];
  logic [31:0] regs4 [0:3];

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int nd4   = 0;
  logic [1:0] last_addr4 = '0;
  logic [7:0] q  [$];
  logic [7:0] q4 [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always #5 clk = ~clk;

  assign rdata  = regs[addr];
  assign rdata4 = regs4[addr4];

  regfile_dump_reader dut (
    .clock(clk), .clear(clear), .start(start),
    .busy(busy), .done(done), .rd_addr(addr),
    .rd_data(rdata), .byte_out(bout),
    .byte_valid(bvalid), .byte_ready(ready)
  );

  regfile_dump_reader #(.NUM_REGS(4), .ADDR_W(2)) dut4 (
    .clock(clk), .clear(clear), .start(start4),
    .busy(busy4), .done(done4), .rd_addr(addr4),
    .rd_data(rdata4), .byte_out(bout4),
    .byte_valid(bvalid4), .byte_ready(ready4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_valid", {31'd0, bvalid}, 32'd1);
      chk("stall_byte", {24'd0, bout}, {24'd0, prev_byte});
    end
    prev_stall = bvalid && !ready && !clear;
    prev_byte  = bout;
    if (bvalid && ready) q.push_back(bout);
    if (done) ndone++;
    if (bvalid4 && ready4) q4.push_back(bout4);
    if (done4) begin
      nd4++;
      last_addr4 = addr4;
    end
  end

  function automatic logic [7:0] exp_byte(input int i);
    int r, b;
    if (i == 0) return 8'hA5;
    r = (i - 1) / 4;
    b = (i - 1) % 4;
    return 8'(regs[r] >> (8 * b));
  endfunction

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, q.size(), 32'd129);
    for (int i = 0; i < q.size() && i < 129; i++)
      chk({tag, "_byte"}, {24'd0, q[i]}, {24'd0, exp_byte(i)});
  endtask

  task automatic run_dump(input bit rnd, input bit mid, input string tag);
    bit seen;
    q.delete();
    ndone = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_hdr_valid"}, {31'd0, bvalid}, 32'd1);
    chk({tag, "_hdr_byte"}, {24'd0, bout}, 32'hA5);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      start = mid && (i == 40 || i == 41 || i == 90);
      if (rnd) ready = 1'($urandom_range(0, 1));
      seen = (ndone > 0);
    end
    start = 1'b0;
    ready = 1'b1;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, ndone, 32'd1);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check_stream(tag);
  endtask

  initial begin
    bit hit;
    clear = 1'b1; start = 1'b0; ready = 1'b1;
    start4 = 1'b0; ready4 = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h01010101;
    for (int i = 0; i < 4; i++) regs4[i] = 32'hC0DE0000 | i;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, bvalid}, 32'd0);
    chk("rst_byte", {24'd0, bout}, 32'd0);
    chk("rst_addr", {27'd0, addr}, 32'd0);
    clear = 1'b0;

    run_dump(1'b0, 1'b0, "t1");

    regs[3] = 32'h12345678;
    run_dump(1'b0, 1'b0, "t2");
    chk("t2_b0", {24'd0, q[13]}, 32'h78);
    chk("t2_b1", {24'd0, q[14]}, 32'h56);
    chk("t2_b2", {24'd0, q[15]}, 32'h34);
    chk("t2_b3", {24'd0, q[16]}, 32'h12);

    run_dump(1'b1, 1'b0, "t3");
    run_dump(1'b0, 1'b1, "t4");

    ndone = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clk); #1;
      hit = bvalid && busy && (addr == 5'd10) && (bout != 8'hA5);
    end
    chk("t5_reach", {31'd0, hit}, 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid", {31'd0, bvalid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_addr", {27'd0, addr}, 32'd0);
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_idle", {31'd0, bvalid}, 32'd0);
    chk("t5_nodone", ndone, 32'd0);
    run_dump(1'b0, 1'b0, "t5r");

    q4.delete();
    nd4 = 0;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (nd4 > 0);
    end
    chk("t6_done_seen", {31'd0, hit}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_done_cnt", nd4, 32'd1);
    chk("t6_last_addr", {30'd0, last_addr4}, 32'd3);
    chk("t6_len", q4.size(), 32'd17);
    for (int i = 0; i < q4.size() && i < 17; i++) begin
      logic [7:0] e;
      if (i == 0) e = 8'hA5;
      else e = 8'(regs4[(i - 1) / 4] >> (8 * ((i - 1) % 4)));
      chk("t6_byte", {24'd0, q4[i]}, {24'd0, e});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
